// File: rtl/sigmoid_gate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sigmoid_gate : two-stage Q8.8 x Q4.12 gating pipeline with clamp counter
// Revision     : 1.0
// ---------------------------------------------------------------------------
module sigmoid_gate #(
  parameter int CNT_W    = 16,
  parameter int GATE_ONE = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_feat,
  input  logic [15:0]      in_gate,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             tile_done,
  output logic [CNT_W-1:0] clamp_cnt,
  input  logic             clamp_clr
);

  localparam logic [15:0] GATE_ONE_16 = 16'(GATE_ONE);

  logic                    s1_valid_q;
  logic                    s1_last_q;
  logic signed [29:0]      s1_prod_q;
  logic                    s2_valid_q;
  logic                    s2_last_q;
  logic [15:0]             s2_data_q;
  logic                    tile_done_q;
  logic [CNT_W-1:0]        clamp_cnt_q;
  logic [CNT_W-1:0]        clamp_cnt_d;

  logic                    s2_load;
  logic                    s1_adv;
  logic                    in_fire;
  logic                    out_fire;
  logic                    gate_over;
  logic [12:0]             gate_clamped;
  logic signed [29:0]      prod;
  logic [15:0]             rounded;
  logic                    unused_prod_bits;

  // Handshake: ready depends only on registered state and out_ready.
  assign out_fire = s2_valid_q && out_ready;
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign gate_over    = in_gate > GATE_ONE_16;
  assign gate_clamped = gate_over ? GATE_ONE_16[12:0] : in_gate[12:0];
  assign prod         = $signed({{14{in_feat[15]}}, in_feat}) * $signed({17'd0, gate_clamped});

  // (p + 2048) >>> 12 == floor(p / 4096) + bit 11; the product range keeps this within 16 bits.
  assign rounded          = s1_prod_q[27:12] + {15'd0, s1_prod_q[11]};
  assign unused_prod_bits = ^{s1_prod_q[29:28], s1_prod_q[10:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_prod_q <= prod;
        s1_last_q <= in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= 16'h0000;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= rounded;
        s2_last_q <= s1_last_q;
      end
    end
  end

  // Clear beats a coincident increment; the count sticks at all-ones.
  always_comb begin
    clamp_cnt_d = clamp_cnt_q;
    if (clamp_clr) begin
      clamp_cnt_d = '0;
    end else if (in_fire && gate_over && !(&clamp_cnt_q)) begin
      clamp_cnt_d = clamp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp_cnt_q <= '0;
      tile_done_q <= 1'b0;
    end else begin
      clamp_cnt_q <= clamp_cnt_d;
      tile_done_q <= out_fire && s2_last_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_last  = s2_last_q;
  assign tile_done = tile_done_q;
  assign clamp_cnt = clamp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_gate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sigmoid_gate : directed self-checking bench for sigmoid_gate
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_sigmoid_gate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_feat = 16'h0000;
  logic [15:0] in_gate = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        tile_done;
  logic [15:0] clamp_cnt;
  logic        clamp_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  sigmoid_gate #(.CNT_W(16), .GATE_ONE(4096)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .in_gate   (in_gate),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .tile_done (tile_done),
    .clamp_cnt (clamp_cnt),
    .clamp_clr (clamp_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sample through an idle pipe; result must appear exactly two cycles later.
  task automatic single(input string tag, input logic [15:0] f, input logic [15:0] g,
                        input logic [15:0] exp, input logic [15:0] cnt);
    @(negedge clk);
    in_valid = 1'b1; in_feat = f; in_gate = g; in_last = 1'b0;
    #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    check({tag, "_cnt"}, 32'(clamp_cnt), 32'(cnt));
  endtask

  task automatic run_stream(input string tag, input int n, input bit rnd, input int last_idx);
    int          sent = 0;
    int          rcv = 0;
    bit          stall = 1'b0;
    bit          done_exp = 1'b0;
    logic [15:0] held = 16'h0;
    logic [7:0]  lfsr = 8'hA5;
    for (int cyc = 0; cyc < 400 && rcv < n; cyc++) begin
      @(negedge clk);
      lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      out_ready = rnd ? lfsr[0] : 1'b1;
      in_valid  = (sent < n);
      in_feat   = 16'(sent * 257);
      in_gate   = 16'h1000;
      in_last   = (sent == last_idx);
      #1;
      check({tag, "_tdone"}, 32'(tile_done), 32'(done_exp));
      if (stall) begin
        check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(out_data), 32'(held));
      end
      done_exp = 1'b0;
      if (out_valid && out_ready) begin
        check({tag, "_data"}, 32'(out_data), 32'(rcv * 257));
        check({tag, "_last"}, 32'(out_last), 32'(rcv == last_idx));
        done_exp = (rcv == last_idx);
        rcv++;
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    check({tag, "_tdone_end"}, 32'(tile_done), 32'(done_exp));
    check({tag, "_count"}, 32'(rcv), 32'(n));
    @(negedge clk);
    #1;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    check({tag, "_tdone_off"}, 32'(tile_done), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_cnt", 32'(clamp_cnt), 32'h0);
    check("rst_tdone", 32'(tile_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_rdy", 32'(in_ready), 32'd1);

    single("half",   16'h0100, 16'h0800, 16'h0080, 16'h0000);
    single("maxpos", 16'h7FFF, 16'h1000, 16'h7FFF, 16'h0000);
    single("maxneg", 16'h8000, 16'h1000, 16'h8000, 16'h0000);
    single("rndup",  16'h0001, 16'h0800, 16'h0001, 16'h0000);
    single("rndneg", 16'hFFFF, 16'h0800, 16'h0000, 16'h0000);
    single("clamp",  16'h0200, 16'hFFFF, 16'h0200, 16'h0001);
    single("clamp1", 16'h0100, 16'h1001, 16'h0100, 16'h0002);
    single("neg3q",  16'hFE00, 16'h0C00, 16'hFE80, 16'h0002);

    @(negedge clk); clamp_clr = 1'b1;
    @(negedge clk); clamp_clr = 1'b0;
    #1 check("clr", 32'(clamp_cnt), 32'h0);

    @(negedge clk);
    in_valid = 1'b1; in_feat = 16'h0200; in_gate = 16'hFFFF;
    repeat (65540) @(negedge clk);
    in_valid = 1'b0;
    #1 check("sat", 32'(clamp_cnt), 32'hFFFF);
    @(negedge clk);
    in_valid = 1'b1; clamp_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clamp_clr = 1'b0;
    #1 check("clr_wins", 32'(clamp_cnt), 32'h0);
    repeat (3) @(negedge clk);

    run_stream("strm", 16, 1'b1, -1);
    run_stream("tile", 8, 1'b0, 7);
    run_stream("tile_bp", 8, 1'b1, 7);

    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_feat = 16'h0300; in_gate = 16'h1000; in_last = 1'b1;
    @(negedge clk);
    in_feat = 16'h0400; in_last = 1'b0;
    #1 check("ar_rdy2", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ar_full_vld", 32'(out_valid), 32'd1);
    check("ar_full_rdy", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("ar_async_vld", 32'(out_valid), 32'd0);
    check("ar_async_data", 32'(out_data), 32'h0);
    check("ar_async_last", 32'(out_last), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ar_rdy_first", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("ar_no_stale", 32'(out_valid), 32'd0);
    check("ar_no_tdone", 32'(tile_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
`default_nettype wire
